// File: rtl/loader_pkg.sv
// Shared definitions for the instruction loader: FSM states and word geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  // Word index to byte address: the fetch side addresses memory in bytes.
  localparam int ADDR_SHIFT     = 2;

endpackage

// File: rtl/byte_assembler.sv
// Packs a big-endian byte stream into 32-bit words (first byte lands in [31:24]).
// Latency: word/word_valid are combinational on the cycle the last byte is taken.
// Backpressure: none; consumes a byte whenever take is high.
// Ports: clk, rst_n (sync, active-low), clear (drop partial word), take (byte
//        handshake), in_byte; word (assembled word), word_valid (4th-byte pulse).
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        take,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  // Only the first three bytes need storing; the fourth is used straight
  // from the input so the word is available on the accepting edge.
  logic [23:0] sr;
  logic [1:0]  cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      sr  <= '0;
      cnt <= '0;
    end else if (take) begin
      sr  <= {sr[15:0], in_byte};
      cnt <= cnt + 2'd1;
    end
  end

  assign word       = {sr, in_byte};
  assign word_valid = take && (cnt == LAST_BYTE);

endmodule

// File: rtl/instruction_loader.sv
// Loads a program byte stream into instruction memory, then checks an XOR checksum.
// Latency: write strobe one cycle after a word's 4th byte; done/error one cycle after checksum.
// Backpressure: none inside a load; in_ready is high for the whole of LOAD and CHECK.
// Ports: clk, rst_n (sync, active-low), start, word_count, in_valid/in_byte/in_ready
//        (byte stream), mem_we/mem_addr/mem_wdata (memory write port),
//        busy, done, error, cpu_hold (status).
module instruction_loader
  import loader_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W + 1)'(1);

  state_t            state;
  // One bit wider than the address so a full-depth load counts up to DEPTH.
  logic [ADDR_W:0]   idx;
  logic [ADDR_W:0]   wc_q;
  logic [31:0]       acc;

  logic              take;
  logic              start_ok;
  logic [31:0]       word;
  logic              word_valid;
  logic [ADDR_W:0]   idx_next;

  assign take     = in_valid && in_ready;
  assign start_ok = start && (state inside {S_IDLE, S_DONE, S_ERROR});
  assign idx_next = idx + IDX_ONE;

  byte_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_ok),
    .take       (take),
    .in_byte    (in_byte),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      wc_q      <= '0;
      acc       <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      cpu_hold  <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
            idx      <= '0;
            acc      <= '0;
            wc_q     <= word_count;
            if (word_count > DEPTH_W) begin
              state <= S_ERROR;
              error <= 1'b1;
            end else begin
              // An empty program goes straight to the checksum, which must be 0.
              state    <= (word_count == '0) ? S_CHECK : S_LOAD;
              busy     <= 1'b1;
              in_ready <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (word_valid) begin
            mem_we    <= 1'b1;
            mem_addr  <= 32'(idx[ADDR_W-1:0]) << ADDR_SHIFT;
            mem_wdata <= word;
            acc       <= acc ^ word;
            idx       <= idx_next;
            if (idx_next == wc_q) state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (word_valid) begin
            busy     <= 1'b0;
            in_ready <= 1'b0;
            if (word == acc) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  word_count;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_hold;

  int vectors = 0;
  int miscompares = 0;
  bit rand_gaps = 1'b0;

  // Write log filled by the monitor below.
  logic [31:0] wr_addr [128];
  logic [31:0] wr_data [128];
  int          wr_n = 0;
  int          base;

  always #5 clk = ~clk;

  instruction_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .cpu_hold   (cpu_hold)
  );

  always @(negedge clk) begin
    if (mem_we === 1'b1 && wr_n < 128) begin
      wr_addr[wr_n] = mem_addr;
      wr_data[wr_n] = mem_wdata;
      wr_n = wr_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one byte; only counts as sent once in_ready was high at the edge.
  task automatic send_byte(input logic [7:0] b);
    bit got = 1'b0;
    int tries = 0;
    while (!got && tries < 50) begin
      @(negedge clk);
      if (rand_gaps && $urandom_range(0, 1) == 0) begin
        in_valid = 1'b0;
        in_byte  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_byte  = b;
        got      = (in_ready === 1'b1);
      end
      tries++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (!got) chk("byte_handshake_timeout", 32'(got), 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic do_start(input logic [5:0] wc);
    @(negedge clk);
    start      = 1'b1;
    word_count = wc;
    @(negedge clk);
    start      = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    word_count = '0;
    in_valid   = 1'b0;
    in_byte    = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we",   32'(mem_we),   32'd0);
    chk("rst_mem_addr", mem_addr,      32'd0);
    chk("rst_wdata",    mem_wdata,     32'd0);
    chk("rst_status",   {28'd0, busy, done, error, cpu_hold}, 32'd0);
    rst_n = 1'b1;

    // Two-word load, good checksum
    base = wr_n;
    do_start(6'd2);
    chk("t1_start_flags", {29'd0, busy, in_ready, cpu_hold}, 32'h7);
    send_word(32'h20080020);
    @(negedge clk);
    chk("t1_we_pulse", {31'd0, mem_we}, 32'd1);
    chk("t1_addr0", mem_addr, 32'h0);
    send_word(32'h20090037);
    send_word(32'h00010017);
    @(negedge clk);
    chk("t1_status", {28'd0, busy, done, error, cpu_hold}, 32'h4);
    chk("t1_nwrites", 32'(wr_n - base), 32'd2);
    chk("t1_w0", wr_data[base], 32'h20080020);
    chk("t1_a1", wr_addr[base+1], 32'h4);
    chk("t1_w1", wr_data[base+1], 32'h20090037);

    // Same load, bad checksum; a start mid-load must be ignored
    base = wr_n;
    do_start(6'd2);
    send_word(32'h20080020);
    do_start(6'd0);
    chk("t2_start_ignored", {30'd0, busy, in_ready}, 32'h3);
    send_word(32'h20090037);
    send_word(32'h00010018);
    @(negedge clk);
    chk("t2_status", {28'd0, busy, done, error, cpu_hold}, 32'h3);
    chk("t2_nwrites", 32'(wr_n - base), 32'd2);

    // Empty program, zero checksum
    base = wr_n;
    do_start(6'd0);
    chk("t3_busy", 32'(busy), 32'd1);
    send_word(32'h00000000);
    @(negedge clk);
    chk("t3_status", {28'd0, busy, done, error, cpu_hold}, 32'h4);
    chk("t3_nwrites", 32'(wr_n - base), 32'd0);

    // Oversize word_count
    base = wr_n;
    do_start(6'd33);
    chk("t4_status", {28'd0, busy, done, error, cpu_hold}, 32'h3);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_byte  = 8'hAA;
      chk("t4_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("t4_nwrites", 32'(wr_n - base), 32'd0);

    // Full-depth load with random in_valid gaps
    base = wr_n;
    rand_gaps = 1'b1;
    do_start(6'd32);
    for (int i = 0; i < 32; i++) send_word(32'hFFFFFFFF);
    send_word(32'h00000000);
    @(negedge clk);
    rand_gaps = 1'b0;
    chk("t5_status", {28'd0, busy, done, error, cpu_hold}, 32'h4);
    chk("t5_nwrites", 32'(wr_n - base), 32'd32);
    chk("t5_last_addr", wr_addr[wr_n-1], 32'h7C);
    chk("t5_last_data", wr_data[wr_n-1], 32'hFFFFFFFF);

    // Reset after 6 bytes of a 2-word load
    base = wr_n;
    do_start(6'd2);
    send_word(32'h20080020);
    send_byte(8'h20);
    send_byte(8'h09);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_nwrites", 32'(wr_n - base), 32'd1);
    chk("t6_addr", wr_addr[base], 32'h0);
    chk("t6_rst_status", {27'd0, in_ready, busy, done, error, cpu_hold}, 32'd0);
    chk("t6_rst_addr", mem_addr, 32'd0);
    chk("t6_rst_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;

    // Fresh load after reset starts at address 0
    base = wr_n;
    do_start(6'd2);
    send_word(32'h20080020);
    send_word(32'h20090037);
    send_word(32'h00010017);
    @(negedge clk);
    chk("t7_status", {28'd0, busy, done, error, cpu_hold}, 32'h4);
    chk("t7_nwrites", 32'(wr_n - base), 32'd2);
    chk("t7_a0", wr_addr[base], 32'h0);
    chk("t7_w1", wr_data[base+1], 32'h20090037);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
